// File: rtl/ray_pixel_scheduler_pkg.sv
// Shared types for the ray pixel scheduler: fixed-point scalar, 3-vector
// and the frame sequencing states.
package ray_pixel_scheduler_pkg;

   localparam int FP_W         = 32;
   localparam int FP_FRAC_BITS = 21;
   localparam int FP_INT_BITS  = FP_W - FP_FRAC_BITS;

   typedef logic signed [FP_W-1:0] fp;

   typedef struct packed {
      fp x;
      fp y;
      fp z;
   } vec3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } sched_state_t;

endpackage

// File: rtl/ray_pixel_scheduler_pixel_counter.sv
// Raster-order x/y pixel counter. x runs fastest; y steps when x wraps.
// 'last' flags the final pixel of the frame from the current count.
module ray_pixel_scheduler_pixel_counter #(
   parameter int H_RES = 640,
   parameter int V_RES = 480,
   parameter int XW    = $clog2(H_RES > 1 ? H_RES : 2),
   parameter int YW    = $clog2(V_RES > 1 ? V_RES : 2)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          advance,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          last
);

   logic x_at_end;
   logic y_at_end;

   assign x_at_end = (x == XW'(H_RES - 1));
   assign y_at_end = (y == YW'(V_RES - 1));
   assign last     = x_at_end && y_at_end;

   // Raster walk: clear at frame load, step once per issued pixel
   always_ff @(posedge clk) begin
      if (!rst) begin
         x <= '0;
         y <= '0;
      end else if (clear) begin
         x <= '0;
         y <= '0;
      end else if (advance) begin
         if (x_at_end) begin
            x <= '0;
            y <= y_at_end ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ray_pixel_scheduler.sv
// Frame-level sequencer for the ray generator. Latches the camera basis at
// frame start, walks the screen in raster order one pixel per cycle, and
// limits rays in flight with a credit counter sized to the result FIFO.
module ray_pixel_scheduler
   import ray_pixel_scheduler_pkg::*;
#(
   parameter int H_RES   = 640,
   parameter int V_RES   = 480,
   parameter int CREDITS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  vec3         cam_forward_in,
   input  vec3         cam_right_in,
   input  logic        credit_return,
   output fp           screen_x,
   output fp           screen_y,
   output logic        pix_valid,
   output vec3         cam_forward,
   output vec3         cam_right,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] frame_count,
   output logic        credit_err
);

   localparam int XW = $clog2(H_RES > 1 ? H_RES : 2);
   localparam int YW = $clog2(V_RES > 1 ? V_RES : 2);
   localparam int CW = $clog2(CREDITS + 1);

   sched_state_t  state;
   logic [CW-1:0] credits;
   logic          credits_full;
   logic          credits_avail;
   logic          issue;
   logic [XW-1:0] pix_x;
   logic [YW-1:0] pix_y;
   logic          pix_last;

   // Integer pixel index to Q11.21: integer bits above, zero fraction
   function automatic fp to_fixed(input logic [FP_INT_BITS-1:0] v);
      return $signed({v, {FP_FRAC_BITS{1'b0}}});
   endfunction

   assign credits_full  = (credits == CW'(CREDITS));
   assign credits_avail = (credits != '0);
   // Issue decision uses the count registered before this edge
   assign issue         = (state == ST_ISSUE) && !abort && credits_avail;

   ray_pixel_scheduler_pixel_counter #(
      .H_RES (H_RES),
      .V_RES (V_RES),
      .XW    (XW),
      .YW    (YW)
   ) u_pixel_counter (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == ST_LOAD),
      .advance (issue),
      .x       (pix_x),
      .y       (pix_y),
      .last    (pix_last)
   );

   // Credit accounting: issue consumes, return refunds, both cancel out
   always_ff @(posedge clk) begin
      if (!rst) begin
         credits    <= CW'(CREDITS);
         credit_err <= 1'b0;
      end else begin
         if (issue && !credit_return) begin
            credits <= credits - 1'b1;
         end else if (credit_return && !issue) begin
            if (credits_full) begin
               credit_err <= 1'b1;
            end else begin
               credits <= credits + 1'b1;
            end
         end
      end
   end

   // Frame sequencer with all outputs registered
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         pix_valid   <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= '0;
         screen_x    <= '0;
         screen_y    <= '0;
         cam_forward <= '0;
         cam_right   <= '0;
      end else begin
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_LOAD;
                  busy  <= 1'b1;
               end
            end
            ST_LOAD: begin
               cam_forward <= cam_forward_in;
               cam_right   <= cam_right_in;
               state       <= ST_ISSUE;
            end
            ST_ISSUE: begin
               if (abort) begin
                  state <= ST_DRAIN;
               end else if (issue) begin
                  pix_valid <= 1'b1;
                  screen_x  <= to_fixed(FP_INT_BITS'(pix_x));
                  screen_y  <= to_fixed(FP_INT_BITS'(pix_y));
                  if (pix_last) begin
                     state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (credits_full) begin
                  state       <= ST_DONE;
                  frame_done  <= 1'b1;
                  frame_count <= frame_count + 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/ray_pixel_scheduler.md
# ray_pixel_scheduler

Frame-level controller that sequences the ray generator. It latches a camera basis at frame start and walks the screen in raster order, issuing one pixel coordinate per cycle. A credit counter caps the number of in-flight rays so downstream buffering never overflows. The block sits between the host/camera register file and `ray_generator`. It drives the generator's `screen_x`, `screen_y`, `valid_in`, `camera_forward` and `camera_right` inputs.

## Interface
Parameters:
- `H_RES`, default 640: pixels per line.
- `V_RES`, default 480: lines per frame.
- `CREDITS`, default 16: maximum rays in flight. Equals the depth of the downstream result FIFO.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. Synchronous, active-low.
- `start`, in, 1: frame request pulse. Honoured only in IDLE.
- `abort`, in, 1: stop issuing, drain, then finish the frame early.
- `cam_forward_in`, in, vec3: camera forward vector from the register file.
- `cam_right_in`, in, vec3: camera right vector from the register file.
- `credit_return`, in, 1: one pulse per ray retired by the consumer.
- `screen_x`, out, fp: pixel x in Q11.21, integer-valued.
- `screen_y`, out, fp: pixel y in Q11.21, integer-valued.
- `pix_valid`, out, 1: drives the generator's `valid_in`.
- `cam_forward`, out, vec3: latched forward vector, held stable for the whole frame.
- `cam_right`, out, vec3: latched right vector, held stable for the whole frame.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `frame_done`, out, 1: one-cycle pulse at frame completion.
- `frame_count`, out, 16: count of completed frames. Wraps.
- `credit_err`, out, 1: sticky. Set when a credit is returned while the counter is already full.

## Operation
- State machine: IDLE → LOAD → ISSUE → DRAIN → DONE → IDLE.
  - IDLE: `start`=1 → LOAD.
  - LOAD, one cycle: latch `cam_forward_in` and `cam_right_in` into `cam_forward` and `cam_right`. Clear the x/y counters. Go to ISSUE.
  - ISSUE, each cycle:
    - Issue when `credits` ≠ 0 and `abort`=0.
    - Issuing drives `pix_valid`=1 with `screen_x` = x<<21 and `screen_y` = y<<21.
    - It then advances x. When x wraps from H_RES-1 to 0, y increments.
    - Issuing pixel (H_RES-1, V_RES-1) → DRAIN.
    - `abort`=1 → DRAIN immediately, with no issue that cycle.
  - DRAIN: wait until `credits` == CREDITS, then → DONE.
  - DONE, one cycle: `frame_done`=1, `frame_count`+1, → IDLE.
- Credit counter, width clog2(CREDITS+1):
  - Issue only: decrement.
  - `credit_return` only: increment.
  - Both in the same cycle: unchanged.
  - Return while full: counter holds at CREDITS and `credit_err` is set. It clears only on reset.
- Stall behaviour: with zero credits, `pix_valid`=0 and the coordinates hold their last issued value.
- `start` while busy is ignored and not queued.
- `cam_*_in` changes during a frame have no effect until the next LOAD.
- `abort` outside ISSUE: in IDLE, LOAD, DRAIN and DONE it is ignored. An abort arriving in LOAD takes effect in the first ISSUE cycle.
- `credit_return` is accepted in every state, including IDLE.

## Timing
- All outputs are registered.
- Reset values: `screen_x`, `screen_y`, `cam_forward`, `cam_right`, `frame_count` = 0. `pix_valid`, `busy`, `frame_done`, `credit_err` = 0. `credits` = CREDITS. State = IDLE.
- `start` sampled at edge k:
  - state = LOAD and `busy`=1 after edge k.
  - camera latched at edge k+1.
  - first `pix_valid`=1 with (0,0) after edge k+2.
- Throughput: one pixel per cycle while credits are available. Total issue cycles ≥ H_RES·V_RES.
- The issue decision uses the credit count registered before the edge, including the `credit_return` sampled at the same edge (simultaneous-event rule above).
- Latency from the last issue to `frame_done`: DRAIN cycles plus one.
- Reset mid-frame: `rst`=0 at any edge restores all reset values on that edge. Outstanding credits are discarded.

## Structure
- Add to `vector_pkg`: `vec3` and `fp` (already present). Add `FP_FRAC_BITS` = 21 to `common_defs`.
- A `pixel_counter` sub-module (x/y raster counter with `advance`, `clear`, `last` outputs) is natural. All other logic is in the top level.

## Test plan
Directed scenarios, with H_RES=4, V_RES=2, CREDITS=4 unless noted:
1. Reset then idle: all outputs 0, `credits`=4. A `start` pulse gives the first `pix_valid` 2 cycles later with `screen_x`=0, `screen_y`=0. The second pixel has `screen_x`=0x00200000.
2. Consumer returns no credits: exactly 4 `pix_valid` pulses, then outputs hold at (3,0). Returning one credit produces exactly one more pixel, (0,1) with `screen_y`=0x00200000.
3. Consumer returns a credit every cycle after a 4-cycle delay: all 8 pixels issue back-to-back. `frame_done` pulses once all 8 credits are back. `frame_count`=1.
4. `cam_forward_in` changed mid-frame: `cam_forward` keeps the start-of-frame value until the next LOAD.
5. `abort` after 3 issues: no further `pix_valid`. `frame_done` follows the return of 3 credits. A second `start` restarts at (0,0).
6. Extra `credit_return` while credits=4: `credit_err`=1 and sticky, credits stay at 4. `rst` mid-ISSUE clears everything the next cycle.
